// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and sequencer for a 4:1 datapath mux.
// One requester owns the mux at a time; its transfers are registered onto out.
module mux_rr_arbiter #(
    parameter int W        = 1,
    parameter int HOLD_MAX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [W-1:0] i0,
    input  logic [W-1:0] i1,
    input  logic [W-1:0] i2,
    input  logic [W-1:0] i3,
    output logic [3:0]   gnt,
    output logic         s0,
    output logic         s1,
    output logic [W-1:0] out,
    output logic         out_valid,
    output logic         busy
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    // A transfer with cnt at this value is the last one the current grant may take.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_e       state_q, state_d;
    logic [1:0]   ptr_q, ptr_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [3:0]   gnt_q, gnt_d;
    logic [1:0]   sel_q, sel_d;
    logic [W-1:0] out_q, out_d;
    logic         out_valid_q, out_valid_d;

    logic [W-1:0] data_sel;
    logic [1:0]   win;
    logic [1:0]   next_ptr;
    logic         xfer;
    logic         release_now;

    // First requester at or after p, searching circularly upward.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        rr_pick = p;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    always_comb begin
        unique case (sel_q)
            2'd0:    data_sel = i0;
            2'd1:    data_sel = i1;
            2'd2:    data_sel = i2;
            default: data_sel = i3;
        endcase
    end

    // NOTE: every signal gets a default before the case, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        xfer        = 1'b0;
        release_now = 1'b0;
        next_ptr    = sel_q + 2'd1;
        win         = rr_pick(req, ptr_q);

        unique case (state_q)
            IDLE: begin
                gnt_d = 4'b0000;
                if (|req) begin
                    gnt_d   = 4'b0001 << win;
                    sel_d   = win;
                    cnt_d   = 8'd0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                xfer        = req[sel_q];
                release_now = !xfer || (cnt_q == HOLD_LAST);
                if (xfer) begin
                    out_d       = data_sel;
                    out_valid_d = 1'b1;
                    cnt_d       = cnt_q + 8'd1;
                end
                if (release_now) begin
                    // Pointer moves past the released owner, so it becomes lowest priority.
                    ptr_d = next_ptr;
                    win   = rr_pick(req, next_ptr);
                    if (|req) begin
                        gnt_d = 4'b0001 << win;
                        sel_d = win;
                        cnt_d = 8'd0;
                    end else begin
                        gnt_d   = 4'b0000;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            cnt_q       <= 8'd0;
            gnt_q       <= 4'b0000;
            sel_q       <= 2'd0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign s0        = sel_q[0];
    assign s1        = sel_q[1];
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed-vector bench for mux_rr_arbiter: a stimulus process queues hand-computed
// post-edge expectations, a monitor process pops and compares them each cycle.
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       i0, i1, i2, i3;
    logic [3:0] gnt;
    logic       s0, s1;
    logic       out;
    logic       out_valid;
    logic       busy;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       vld;
        logic       out;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    mux_rr_arbiter #(.W(1), .HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .i0        (i0),
        .i1        (i1),
        .i2        (i2),
        .i3        (i3),
        .gnt       (gnt),
        .s0        (s0),
        .s1        (s1),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int vec, input logic [7:0] act, input logic [7:0] expv);
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, vec, act, expv);
        end
    endtask

    // Drive one input vector n times on falling edges; each repeat queues the
    // outputs expected after the following rising edge.
    task automatic apply(input logic r, input logic [3:0] rq, input logic [3:0] d,
                         input logic [3:0] eg, input logic [1:0] es, input logic eb,
                         input logic ev, input logic eo, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst_n = r;
            req   = rq;
            {i3, i2, i1, i0} = d;
            e.gnt  = eg;
            e.sel  = es;
            e.busy = eb;
            e.vld  = ev;
            e.out  = eo;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: compare one queued expectation per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                check("gnt",       vectors, {4'd0, gnt},       {4'd0, e.gnt});
                check("sel",       vectors, {6'd0, s1, s0},    {6'd0, e.sel});
                check("busy",      vectors, {7'd0, busy},      {7'd0, e.busy});
                check("out_valid", vectors, {7'd0, out_valid}, {7'd0, e.vld});
                check("out",       vectors, {7'd0, out},       {7'd0, e.out});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        {i3, i2, i1, i0} = 4'b0000;

        //     rst  req      data     gnt      sel  bsy  vld  out  n
        // Reset with all requests active, then release.
        apply(0, 4'b1111, 4'b0001, 4'b0000, 2'd0, 0, 0, 0, 2);
        apply(1, 4'b1111, 4'b0001, 4'b0001, 2'd0, 1, 0, 0, 1);
        apply(1, 4'b1111, 4'b0001, 4'b0001, 2'd0, 1, 1, 1, 1);
        // Reset mid-grant, then full contention rotation (i0..i3 = 0,1,1,0).
        apply(0, 4'b1111, 4'b0110, 4'b0000, 2'd0, 0, 0, 0, 1);
        apply(1, 4'b1111, 4'b0110, 4'b0001, 2'd0, 1, 0, 0, 1);
        apply(1, 4'b1111, 4'b0110, 4'b0001, 2'd0, 1, 1, 0, 3);
        apply(1, 4'b1111, 4'b0110, 4'b0010, 2'd1, 1, 1, 0, 1);
        apply(1, 4'b1111, 4'b0110, 4'b0010, 2'd1, 1, 1, 1, 3);
        apply(1, 4'b1111, 4'b0110, 4'b0100, 2'd2, 1, 1, 1, 4);
        apply(1, 4'b1111, 4'b0110, 4'b1000, 2'd3, 1, 1, 1, 1);
        apply(1, 4'b1111, 4'b0110, 4'b1000, 2'd3, 1, 1, 0, 3);
        apply(1, 4'b1111, 4'b0110, 4'b0001, 2'd0, 1, 1, 0, 1);
        // Owner drops its request: no transfer, back to idle, selects hold.
        apply(1, 4'b0000, 4'b0110, 4'b0000, 2'd0, 0, 0, 0, 1);
        // Single requester 2, three transfers, then release (ptr -> 3).
        apply(1, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 0, 0, 1);
        apply(1, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 1, 1, 3);
        apply(1, 4'b0000, 4'b0100, 4'b0000, 2'd2, 0, 0, 1, 1);
        // All request: requester 3 wins first.
        apply(1, 4'b1111, 4'b0100, 4'b1000, 2'd3, 1, 0, 1, 1);
        // Wrap-around: requester 3 expires, ptr wraps to 0, then back to 3.
        apply(1, 4'b1001, 4'b1000, 4'b1000, 2'd3, 1, 1, 1, 3);
        apply(1, 4'b1001, 4'b1000, 4'b0001, 2'd0, 1, 1, 1, 1);
        apply(1, 4'b1001, 4'b1000, 4'b0001, 2'd0, 1, 1, 0, 3);
        apply(1, 4'b1001, 4'b1000, 4'b1000, 2'd3, 1, 1, 0, 1);
        apply(1, 4'b0000, 4'b1000, 4'b0000, 2'd3, 0, 0, 0, 1);
        // Sole requester 1 across two hold expiries: grant and valid never drop.
        apply(1, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1, 0, 0, 1);
        apply(1, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1, 1, 1, 9);
        apply(1, 4'b0000, 4'b0010, 4'b0000, 2'd1, 0, 0, 1, 1);
        // Grant to 2 with two transfers, reset pulse, then 1 gets a full hold.
        apply(1, 4'b0100, 4'b0110, 4'b0100, 2'd2, 1, 0, 1, 1);
        apply(1, 4'b0100, 4'b0110, 4'b0100, 2'd2, 1, 1, 1, 2);
        apply(0, 4'b0110, 4'b0110, 4'b0000, 2'd0, 0, 0, 0, 1);
        apply(1, 4'b0110, 4'b0110, 4'b0010, 2'd1, 1, 0, 0, 1);
        apply(1, 4'b0110, 4'b0110, 4'b0010, 2'd1, 1, 1, 1, 3);
        apply(1, 4'b0110, 4'b0110, 4'b0100, 2'd2, 1, 1, 1, 1);
        apply(1, 4'b0000, 4'b0110, 4'b0000, 2'd2, 0, 0, 1, 1);

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
